// File: rtl/levinson_pkg.sv
// Shared types and constants for the Levinson-Durbin sequencer and its datapath.
// State encoding, index-width helper and datapath mux codes live here.
package levinson_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_INIT     = 4'd1,
      S_QINIT    = 4'd2,
      S_QACC     = 4'd3,
      S_DIV_REQ  = 4'd4,
      S_DIV_WAIT = 4'd5,
      S_TMP      = 4'd6,
      S_UPD_E    = 4'd7,
      S_UPD_A    = 4'd8,
      S_NEXT     = 4'd9,
      S_DONE     = 4'd10,
      S_FAIL     = 4'd11
   } state_t;

   // a-write source: fresh k, or the a[j] - k*tmp[j] update
   localparam logic OUT_SEL_K   = 1'b0;
   localparam logic OUT_SEL_UPD = 1'b1;

   localparam logic E_SEL_R0    = 1'b0;
   localparam logic E_SEL_UPD   = 1'b1;

   localparam logic Q_SEL_R     = 1'b0;
   localparam logic Q_SEL_ACC   = 1'b1;

   function automatic int idx_w(input int order);
      return (order < 1) ? 1 : $clog2(order + 1);
   endfunction

endpackage

// File: rtl/levinson_seq_ctrl_if.sv
// Control bundle between the Levinson sequencer and the LPC datapath.
// master = sequencer side, slave = datapath/divider side.
interface levinson_seq_ctrl_if #(
   parameter int IDX_W = 4
) ();

   logic             start;
   logic             busy;
   logic             done;
   logic             fail;
   logic [IDX_W-1:0] order_out;
   logic             e_nonpos;
   logic             div_start;
   logic             div_done;
   logic [IDX_W-1:0] r_raddr;
   logic [IDX_W-1:0] a_raddr;
   logic [IDX_W-1:0] a_waddr;
   logic             a_we;
   logic [IDX_W-1:0] tmp_addr;
   logic             tmp_we;
   logic             out_sel;
   logic             e_sel;
   logic             q_sel;
   logic             q_load;
   logic             e_load;
   logic             k_load;

   modport master (
      input  start, e_nonpos, div_done,
      output busy, done, fail, order_out, div_start,
      output r_raddr, a_raddr, a_waddr, a_we,
      output tmp_addr, tmp_we,
      output out_sel, e_sel, q_sel,
      output q_load, e_load, k_load
   );

   modport slave (
      output start, e_nonpos, div_done,
      input  busy, done, fail, order_out, div_start,
      input  r_raddr, a_raddr, a_waddr, a_we,
      input  tmp_addr, tmp_we,
      input  out_sel, e_sel, q_sel,
      input  q_load, e_load, k_load
   );

endinterface

// File: rtl/levinson_idx_cnt.sv
// Loadable down-counter for the inner index j, with zero/one compares.
// Exposes its next value so the sequencer can register addresses ahead.
module levinson_idx_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] val,
   output logic [W-1:0] cnt,
   output logic [W-1:0] nxt,
   output logic         zero,
   output logic         one
);

   always_comb begin
      nxt = cnt;
      if (load)
         nxt = val;
      else if (dec)
         nxt = cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else
         cnt <= nxt;
   end

   assign zero = (cnt == '0);
   assign one  = (cnt == W'(1));

endmodule

// File: rtl/levinson_seq_ctrl.sv
// Levinson-Durbin recursion sequencer: drives r/a/tmp addressing, q/e/k
// loads and the k divider handshake, with abort on non-positive error.
module levinson_seq_ctrl
   import levinson_pkg::*;
#(
   parameter int ORDER = 10,
   parameter int IDX_W = idx_w(ORDER)
) (
   input  logic                clk,
   input  logic                reset,
   levinson_seq_ctrl_if.master bus
);

   typedef struct packed {
      logic             busy;
      logic             done;
      logic             fail;
      logic [IDX_W-1:0] order_out;
      logic             div_start;
      logic [IDX_W-1:0] r_raddr;
      logic [IDX_W-1:0] a_raddr;
      logic [IDX_W-1:0] a_waddr;
      logic             a_we;
      logic [IDX_W-1:0] tmp_addr;
      logic             tmp_we;
      logic             out_sel;
      logic             e_sel;
      logic             q_sel;
      logic             q_load;
      logic             e_load;
   } ctl_t;

   state_t           state;
   state_t           nxt_state;
   logic [IDX_W-1:0] i;
   logic [IDX_W-1:0] nxt_i;
   logic [IDX_W-1:0] j;
   logic [IDX_W-1:0] nxt_j;
   logic [IDX_W-1:0] j_val;
   logic             j_load;
   logic             j_dec;
   logic             j_zero;
   logic             j_one;
   ctl_t             ctl;
   ctl_t             ctl_d;

   levinson_idx_cnt #(
      .W (IDX_W)
   ) u_j (
      .clk   (clk),
      .reset (reset),
      .load  (j_load),
      .dec   (j_dec),
      .val   (j_val),
      .cnt   (j),
      .nxt   (nxt_j),
      .zero  (j_zero),
      .one   (j_one)
   );

   always_comb begin
      nxt_state = state;
      nxt_i     = i;
      j_load    = 1'b0;
      j_dec     = 1'b0;
      j_val     = '0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               nxt_state = S_INIT;
               nxt_i     = '0;
               j_load    = 1'b1;
            end
         end
         S_INIT:
            nxt_state = S_QINIT;
         S_QINIT: begin
            j_load    = 1'b1;
            j_val     = i;
            nxt_state = (i != '0) ? S_QACC : S_DIV_REQ;
         end
         S_QACC: begin
            j_dec = 1'b1;
            if (j_one)
               nxt_state = S_DIV_REQ;
         end
         S_DIV_REQ: begin
            j_load    = 1'b1;
            j_val     = i;
            nxt_state = bus.e_nonpos ? S_FAIL : S_DIV_WAIT;
         end
         S_DIV_WAIT: begin
            if (bus.div_done)
               nxt_state = (i != '0) ? S_TMP : S_UPD_E;
         end
         S_TMP: begin
            j_dec = 1'b1;
            if (j_one)
               nxt_state = S_UPD_E;
         end
         S_UPD_E: begin
            if (i != '0) begin
               j_load    = 1'b1;
               j_val     = i - 1'b1;
               nxt_state = S_UPD_A;
            end else begin
               nxt_state = S_NEXT;
            end
         end
         S_UPD_A: begin
            if (j_zero)
               nxt_state = S_NEXT;
            else
               j_dec = 1'b1;
         end
         S_NEXT: begin
            nxt_i     = i + 1'b1;
            nxt_state = (i == IDX_W'(ORDER - 1)) ? S_DONE : S_QINIT;
         end
         S_DONE, S_FAIL:
            nxt_state = S_IDLE;
         default: begin
            nxt_state = S_IDLE;
            nxt_i     = '0;
            j_load    = 1'b1;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      ctl_d      = '0;
      ctl_d.busy = (nxt_state != S_IDLE);
      unique case (nxt_state)
         S_INIT: begin
            ctl_d.e_sel  = E_SEL_R0;
            ctl_d.e_load = 1'b1;
         end
         S_QINIT: begin
            ctl_d.r_raddr = nxt_i + 1'b1;
            ctl_d.q_sel   = Q_SEL_R;
            ctl_d.q_load  = 1'b1;
         end
         S_QACC: begin
            ctl_d.r_raddr = nxt_j;
            ctl_d.a_raddr = nxt_i - nxt_j;
            ctl_d.q_sel   = Q_SEL_ACC;
            ctl_d.q_load  = 1'b1;
         end
         S_DIV_REQ:
            ctl_d.div_start = 1'b1;
         S_TMP: begin
            ctl_d.a_raddr  = nxt_j - 1'b1;
            ctl_d.tmp_addr = nxt_i - nxt_j;
            ctl_d.tmp_we   = 1'b1;
         end
         S_UPD_E: begin
            ctl_d.a_waddr = nxt_i;
            ctl_d.a_we    = 1'b1;
            ctl_d.out_sel = OUT_SEL_K;
            ctl_d.e_sel   = E_SEL_UPD;
            ctl_d.e_load  = 1'b1;
         end
         S_UPD_A: begin
            ctl_d.a_raddr  = nxt_j;
            ctl_d.a_waddr  = nxt_j;
            ctl_d.tmp_addr = nxt_j;
            ctl_d.a_we     = 1'b1;
            ctl_d.out_sel  = OUT_SEL_UPD;
         end
         S_DONE: begin
            ctl_d.done      = 1'b1;
            ctl_d.order_out = IDX_W'(ORDER);
         end
         S_FAIL: begin
            ctl_d.done      = 1'b1;
            ctl_d.fail      = 1'b1;
            ctl_d.order_out = nxt_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         i     <= '0;
         ctl   <= '0;
      end else begin
         state <= nxt_state;
         i     <= nxt_i;
         ctl   <= ctl_d;
      end
   end

   // Divider must never launch on a non-positive error
   assign bus.div_start = ctl.div_start & ~bus.e_nonpos;
   assign bus.k_load    = (state == S_DIV_WAIT) & bus.div_done;

   assign bus.busy      = ctl.busy;
   assign bus.done      = ctl.done;
   assign bus.fail      = ctl.fail;
   assign bus.order_out = ctl.order_out;
   assign bus.r_raddr   = ctl.r_raddr;
   assign bus.a_raddr   = ctl.a_raddr;
   assign bus.a_waddr   = ctl.a_waddr;
   assign bus.a_we      = ctl.a_we;
   assign bus.tmp_addr  = ctl.tmp_addr;
   assign bus.tmp_we    = ctl.tmp_we;
   assign bus.out_sel   = ctl.out_sel;
   assign bus.e_sel     = ctl.e_sel;
   assign bus.q_sel     = ctl.q_sel;
   assign bus.q_load    = ctl.q_load;
   assign bus.e_load    = ctl.e_load;

endmodule

// File: tb/tb_levinson_seq_ctrl.sv
// Directed bench for levinson_seq_ctrl: ORDER=2 address trace and
// ORDER=10 stall, abort, start-ignore and mid-run reset scenarios.
module tb_levinson_seq_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   levinson_seq_ctrl_if #(.IDX_W(2)) b2 ();
   levinson_seq_ctrl_if #(.IDX_W(4)) b10 ();

   levinson_seq_ctrl #(.ORDER(2)) u2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2.master)
   );

   levinson_seq_ctrl #(.ORDER(10)) u10 (
      .clk   (clk),
      .reset (reset),
      .bus   (b10.master)
   );

   logic [16:0] tr2;
   logic [24:0] tr10;
   logic [11:0] flags;

   assign tr2 = {b2.r_raddr, b2.a_raddr, b2.a_waddr, b2.tmp_addr,
                 b2.a_we, b2.tmp_we, b2.out_sel, b2.e_sel, b2.q_sel,
                 b2.q_load, b2.e_load, b2.k_load, b2.div_start};
   assign tr10 = {b10.r_raddr, b10.a_raddr, b10.a_waddr, b10.tmp_addr,
                  b10.a_we, b10.tmp_we, b10.out_sel, b10.e_sel, b10.q_sel,
                  b10.q_load, b10.e_load, b10.k_load, b10.div_start};
   assign flags = {b2.busy, b2.done, b2.fail, b2.order_out,
                   b10.busy, b10.done, b10.fail, b10.order_out};

   // divider models: div_done arrives ext+1 cycles after div_start
   int ext2 = 0, cnt2 = 0;
   int ext10 = 0, cnt10 = 0, ds10 = 0, dd10 = 0, fbase = 0;
   bit fmode = 1'b0;

   always @(negedge clk) begin
      b2.e_nonpos = 1'b0;
      b2.div_done = 1'b0;
      if (reset) cnt2 = 0;
      else begin
         if (cnt2 > 0) begin
            cnt2--;
            if (cnt2 == 0) b2.div_done = 1'b1;
         end
         if (b2.div_start) cnt2 = ext2 + 1;
      end
   end

   always @(negedge clk) begin
      b10.e_nonpos = fmode && (dd10 - fbase >= 3);
      b10.div_done = 1'b0;
      if (reset) cnt10 = 0;
      else begin
         if (cnt10 > 0) begin
            cnt10--;
            if (cnt10 == 0) begin
               b10.div_done = 1'b1;
               dd10++;
            end
         end
         if (b10.div_start) begin
            cnt10 = ext10 + 1;
            ds10++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // {r,a,aw,tmp} 2b each, then a_we,tmp_we,out,e_sel,q_sel,q_ld,e_ld,k_ld,div
   function automatic logic [16:0] exp2(input int k);
      case (k)
         1:  return {8'h00, 9'b000000100};
         2:  return {8'h40, 9'b000001000};
         3:  return {8'h00, 9'b000000001};
         4:  return {8'h00, 9'b000000010};
         5:  return {8'h00, 9'b100100100};
         6:  return {8'h00, 9'b000000000};
         7:  return {8'h80, 9'b000001000};
         8:  return {8'h40, 9'b000011000};
         9:  return {8'h00, 9'b000000001};
         10: return {8'h00, 9'b000000010};
         11: return {8'h00, 9'b010000000};
         12: return {8'h04, 9'b100100100};
         13: return {8'h00, 9'b101000000};
         default: return '0;
      endcase
   endfunction

   task automatic run10(input int poke, output int lat, output int kl);
      int t0;
      @(negedge clk);
      b10.start = 1'b1;
      t0 = cyc + 1;
      lat = -1;
      kl = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         b10.start = (n == poke);
         #1;
         if (b10.k_load) kl++;
         if (b10.done) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   int lat, kl, t0, dsb;
   bit found;

   initial begin
      b2.start = 1'b0;
      b10.start = 1'b0;
      reset = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("rst_tr2", 32'(tr2), 32'd0);
      chk("rst_tr10", 32'(tr10), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // ORDER=2 full output trace
      @(negedge clk);
      b2.start = 1'b1;
      t0 = cyc + 1;
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         b2.start = 1'b0;
         #1;
         if (n < 14)
            chk($sformatf("tr2_c%0d", n + 1), 32'(tr2), 32'(exp2(n + 1)));
         if (b2.done) begin
            lat = cyc - t0;
            break;
         end
      end
      chk("o2_lat", lat, 14);
      chk("o2_fail", 32'(b2.fail), 32'd0);
      chk("o2_order", 32'(b2.order_out), 32'd2);
      chk("o2_busy_done", 32'(b2.busy), 32'd1);
      @(negedge clk);
      #1 chk("o2_idle", 32'(b2.busy), 32'd0);

      // ORDER=10 with 3 extra divider cycles
      ext10 = 3;
      run10(-1, lat, kl);
      chk("stall_lat", lat, 216);
      chk("stall_kl", kl, 10);
      chk("stall_fail", 32'(b10.fail), 32'd0);
      chk("stall_order", 32'(b10.order_out), 32'd10);

      // abort at i=3
      ext10 = 0;
      @(negedge clk);
      fbase = dd10;
      dsb = ds10;
      fmode = 1'b1;
      run10(-1, lat, kl);
      fmode = 1'b0;
      chk("abort_lat", lat, 30);
      chk("abort_fail", 32'(b10.fail), 32'd1);
      chk("abort_order", 32'(b10.order_out), 32'd3);
      chk("abort_divs", ds10 - dsb, 3);
      chk("abort_kl", kl, 3);
      @(negedge clk);
      #1 chk("abort_idle", 32'(b10.busy), 32'd0);

      // starts mid-run and on DONE are ignored
      run10(40, lat, kl);
      chk("ign_lat", lat, 186);
      b10.start = 1'b1;
      @(negedge clk);
      b10.start = 1'b0;
      #1 chk("ign_done_start", 32'(b10.busy), 32'd0);
      run10(-1, lat, kl);
      chk("rerun_lat", lat, 186);
      chk("rerun_order", 32'(b10.order_out), 32'd10);

      // async reset mid-QACC
      @(negedge clk);
      b10.start = 1'b1;
      @(negedge clk);
      b10.start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         #1;
         if (b10.q_load && b10.q_sel) begin
            found = 1'b1;
            break;
         end
      end
      chk("qacc_found", 32'(found), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_tr10", 32'(tr10), 32'd0);
      chk("mid_rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run10(-1, lat, kl);
      chk("post_rst_lat", lat, 186);
      chk("post_rst_fail", 32'(b10.fail), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
